// File: rtl/id_inst_queue_if.sv
// Interface between the Icache response, flow control and the ID decode stage.
// The queue sits on the slave side; whatever feeds and consumes it uses master.
interface id_inst_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             icache_ready_i;
  logic [XLEN-1:0]  icache_inst_i;
  logic [PC_W-1:0]  icache_pc_i;
  logic             fc_stall_id_i;
  logic             fc_flush_id_i;
  logic             id_bubble_i;

  logic [XLEN-1:0]  iq_inst_o;
  logic [PC_W-1:0]  iq_pc_o;
  logic             iq_valid_o;
  logic             iq_full_o;
  logic             iq_almost_full_o;
  logic [CNT_W-1:0] iq_count_o;
  logic             iq_overflow_o;

  modport master (
    output icache_ready_i, icache_inst_i, icache_pc_i,
    output fc_stall_id_i, fc_flush_id_i, id_bubble_i,
    input  iq_inst_o, iq_pc_o, iq_valid_o,
    input  iq_full_o, iq_almost_full_o, iq_count_o, iq_overflow_o
  );

  modport slave (
    input  icache_ready_i, icache_inst_i, icache_pc_i,
    input  fc_stall_id_i, fc_flush_id_i, id_bubble_i,
    output iq_inst_o, iq_pc_o, iq_valid_o,
    output iq_full_o, iq_almost_full_o, iq_count_o, iq_overflow_o
  );
endinterface

// File: rtl/id_inst_queue.sv
// DEPTH-entry {pc, inst} FIFO between Icache and ID with empty-queue bypass,
// load-use bubble insertion and post-flush squash of stale Icache returns.
module id_inst_queue #(
  parameter int unsigned     DEPTH      = 4,
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     PC_W       = 32,
  parameter int unsigned     SQUASH_CYC = 1,
  parameter int unsigned     AF_LEVEL   = DEPTH - 1,
  parameter logic [XLEN-1:0] NOP_INST   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  id_inst_queue_if.slave    iq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t     mem_q [DEPTH];
  ptr_t       rd_ptr_q, rd_ptr_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  cnt_t       count_q, count_d;
  logic [2:0] squash_q, squash_d;
  logic       overflow_q, overflow_d;

  logic            empty, full;
  logic            in_v, take, push_req, push, pop;
  logic            out_valid;
  logic [XLEN-1:0] out_inst;
  logic [PC_W-1:0] out_pc;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A return is only accepted outside the squash window, and never while reset
  // holds the queue, so outputs show the idle state for the whole reset.
  assign in_v = rst_n && iq.icache_ready_i && (squash_q == '0) && !iq.fc_flush_id_i;

  // NOTE: every signal driven here gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    out_inst  = NOP_INST;
    out_pc    = '0;
    out_valid = 1'b0;
    if (!(iq.id_bubble_i || iq.fc_flush_id_i)) begin
      if (!empty) begin
        out_inst  = mem_q[rd_ptr_q].inst;
        out_pc    = mem_q[rd_ptr_q].pc;
        out_valid = 1'b1;
      end else if (in_v) begin
        out_inst  = iq.icache_inst_i;
        out_pc    = iq.icache_pc_i;
        out_valid = 1'b1;
      end
    end
  end

  assign take = out_valid && !iq.fc_stall_id_i && !iq.id_bubble_i && !iq.fc_flush_id_i;
  assign pop  = take && !empty;

  // A bypassed instruction that ID consumes this cycle never needs storage.
  assign push_req = in_v && !(empty && take);
  assign push     = push_req && (!full || pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    squash_d   = (squash_q != '0) ? squash_q - 3'd1 : squash_q;
    overflow_d = overflow_q || (push_req && full && !pop);

    if (iq.fc_flush_id_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      squash_d = 3'(SQUASH_CYC);
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      squash_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      squash_q   <= squash_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale
  // contents are never visible and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: iq.icache_pc_i, inst: iq.icache_inst_i};
  end

  assign iq.iq_inst_o        = out_inst;
  assign iq.iq_pc_o          = out_pc;
  assign iq.iq_valid_o       = out_valid;
  assign iq.iq_full_o        = full;
  assign iq.iq_almost_full_o = (count_q >= CNT_W'(AF_LEVEL));
  assign iq.iq_count_o       = count_q;
  assign iq.iq_overflow_o    = overflow_q;

endmodule

// File: tb/tb_id_inst_queue.sv
// Self-checking bench for id_inst_queue: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_id_inst_queue;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned SQUASH_CYC = 1;
  localparam int unsigned AF_LEVEL   = DEPTH - 1;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_inst_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .PC_W(PC_W)) iq_if ();

  id_inst_queue #(
    .DEPTH(DEPTH), .XLEN(XLEN), .PC_W(PC_W), .SQUASH_CYC(SQUASH_CYC),
    .AF_LEVEL(AF_LEVEL), .NOP_INST(NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iq    (iq_if)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t model_q[$];
  int   squash;
  bit   ovf;
  int   checks;
  int   errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    squash = 0;
    ovf    = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".inst"},  iq_if.iq_inst_o,        NOP);
    check({tag, ".pc"},    iq_if.iq_pc_o,          0);
    check({tag, ".valid"}, iq_if.iq_valid_o,       0);
    check({tag, ".full"},  iq_if.iq_full_o,        0);
    check({tag, ".af"},    iq_if.iq_almost_full_o, 0);
    check({tag, ".count"}, iq_if.iq_count_o,       0);
    check({tag, ".ovf"},   iq_if.iq_overflow_o,    0);
  endtask

  // One clock: drive at the falling edge, check combinational outputs 1ns later
  // (well away from the rising edge), then advance the model across that edge.
  task automatic cycle(input string tag, input bit ready, input logic [31:0] inst,
                       input logic [31:0] pc, input bit stall, input bit flush,
                       input bit bubble);
    bit          inv, was_empty, take, exp_v;
    logic [31:0] exp_inst, exp_pc;
    @(negedge clk);
    iq_if.icache_ready_i = ready;
    iq_if.icache_inst_i  = inst;
    iq_if.icache_pc_i    = pc;
    iq_if.fc_stall_id_i  = stall;
    iq_if.fc_flush_id_i  = flush;
    iq_if.id_bubble_i    = bubble;
    #1;
    inv       = ready && (squash == 0) && !flush;
    was_empty = (model_q.size() == 0);
    exp_inst  = NOP;
    exp_pc    = '0;
    exp_v     = 1'b0;
    if (!(bubble || flush)) begin
      if (!was_empty) begin
        exp_inst = model_q[0].inst;
        exp_pc   = model_q[0].pc;
        exp_v    = 1'b1;
      end else if (inv) begin
        exp_inst = inst;
        exp_pc   = pc;
        exp_v    = 1'b1;
      end
    end
    check({tag, ".inst"},  iq_if.iq_inst_o,        exp_inst);
    check({tag, ".pc"},    iq_if.iq_pc_o,          exp_pc);
    check({tag, ".valid"}, iq_if.iq_valid_o,       exp_v);
    check({tag, ".count"}, iq_if.iq_count_o,       model_q.size());
    check({tag, ".full"},  iq_if.iq_full_o,        model_q.size() == DEPTH);
    check({tag, ".af"},    iq_if.iq_almost_full_o, model_q.size() >= AF_LEVEL);
    check({tag, ".ovf"},   iq_if.iq_overflow_o,    ovf);

    take = exp_v && !stall && !bubble && !flush;
    if (flush) begin
      model_q.delete();
      squash = SQUASH_CYC;
    end else begin
      if (squash > 0) squash--;
      if (take && !was_empty) void'(model_q.pop_front());
      if (inv && !(take && was_empty)) begin
        if (model_q.size() < DEPTH) model_q.push_back('{pc: pc, inst: inst});
        else ovf = 1'b1;
      end
    end
  endtask

  task automatic idle(input string tag, input bit stall);
    cycle(tag, 1'b0, 32'h0, 32'h0, stall, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst_n = 1'b0;
    iq_if.icache_ready_i = 1'b0;
    iq_if.icache_inst_i  = '0;
    iq_if.icache_pc_i    = '0;
    iq_if.fc_stall_id_i  = 1'b0;
    iq_if.fc_flush_id_i  = 1'b0;
    iq_if.id_bubble_i    = 1'b0;
    #3;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-latency bypass of an empty queue.
    cycle("bypass", 1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0, 1'b0);
    check("bypass.lit_inst", iq_if.iq_inst_o, 32'h0050_0093);
    check("bypass.lit_pc",   iq_if.iq_pc_o,   32'h100);
    idle("bypass.after", 1'b0);

    // Fill under stall, overflow on the fifth, then drain in order.
    for (int i = 0; i < 5; i++)
      cycle($sformatf("fill%0d", i), 1'b1, 32'h1000 + i, 32'h300 + 4 * i, 1'b1, 1'b0, 1'b0);
    idle("fill.hold", 1'b1);
    check("fill.lit_ovf",  iq_if.iq_overflow_o, 1);
    check("fill.lit_full", iq_if.iq_full_o,     1);
    for (int i = 0; i < 4; i++) begin
      idle($sformatf("drain%0d", i), 1'b0);
      check($sformatf("drain%0d.lit_pc", i), iq_if.iq_pc_o, 32'h300 + 4 * i);
    end
    idle("drain.empty", 1'b0);

    // Steady push/pop at occupancy 1 walks the pointers round twice.
    cycle("wrap.seed", 1'b1, 32'h2000, 32'h400, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      cycle($sformatf("wrap%0d", i), 1'b1, 32'h2000 + i, 32'h400 + 4 * i, 1'b0, 1'b0, 1'b0);
    idle("wrap.last", 1'b0);
    idle("wrap.empty", 1'b0);

    // Load-use bubble holds the head without consuming it.
    cycle("bub.push0", 1'b1, 32'h3000, 32'h200, 1'b1, 1'b0, 1'b0);
    cycle("bub.push1", 1'b1, 32'h3004, 32'h204, 1'b1, 1'b0, 1'b0);
    cycle("bub.nop", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("bub.lit_valid", iq_if.iq_valid_o, 0);
    check("bub.lit_count", iq_if.iq_count_o, 2);
    idle("bub.take", 1'b0);
    check("bub.lit_pc", iq_if.iq_pc_o, 32'h200);
    idle("bub.drain", 1'b0);

    // Flush with a simultaneous return, then one squashed return, then bypass.
    for (int i = 0; i < 3; i++)
      cycle($sformatf("fl.push%0d", i), 1'b1, 32'h4000 + i, 32'h500 + 4 * i, 1'b1, 1'b0, 1'b0);
    cycle("fl.flush", 1'b1, 32'h4100, 32'h600, 1'b0, 1'b1, 1'b0);
    cycle("fl.squash", 1'b1, 32'h4104, 32'h604, 1'b0, 1'b0, 1'b0);
    check("fl.lit_valid", iq_if.iq_valid_o, 0);
    cycle("fl.bypass", 1'b1, 32'h4108, 32'h608, 1'b0, 1'b0, 1'b0);
    check("fl.lit_pc", iq_if.iq_pc_o, 32'h608);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle($sformatf("rnd%0d", i), $urandom_range(0, 9) < 6, $urandom, $urandom,
            $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0);

    // Asynchronous reset while full, checked before any clock edge.
    idle("ar.pre", 1'b0);
    for (int i = 0; i < 6; i++)
      cycle($sformatf("ar.fill%0d", i), 1'b1, 32'h5000 + i, 32'h700 + 4 * i, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    iq_if.icache_ready_i = 1'b0;
    iq_if.fc_stall_id_i  = 1'b0;
    iq_if.fc_flush_id_i  = 1'b0;
    iq_if.id_bubble_i    = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("areset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle("ar.post", 1'b0);
    cycle("ar.bypass", 1'b1, 32'h6000, 32'h800, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
